// File: rtl/floo_route_sel_unit_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// floo_route_sel_unit_if
// Flit-side bundle of one router input port as seen by the route selection
// unit. The master drives the head-flit routing fields and the handshake
// and receives the selected route. The slave is the route selection unit.
//
// Signals (direction from the slave's point of view):
//   dst_x_i/dst_y_i     in   destination coordinate
//   src_x_i/src_y_i     in   source coordinate (multicast)
//   mask_x_i/mask_y_i   in   multicast don't-care bits
//   mcast_i             in   flit is a multicast
//   last_i              in   tail flit
//   valid_i, ready_i    in   flit handshake
//   route_sel_o         out  one-hot / multi-hot output-port mask
//   route_sel_id_o      out  binary output-port index
//   dec_error_o         out  ID-table miss
//   mismatch_o          out  locked route differs from fresh route
// -----------------------------------------------------------------------------
interface floo_route_sel_unit_if #(
  parameter int unsigned XWidth        = 3,
  parameter int unsigned YWidth        = 3,
  parameter int unsigned NumRoutes     = 5,
  parameter int unsigned RouteSelWidth = $clog2(NumRoutes)
);

  logic [XWidth-1:0]        dst_x_i;
  logic [YWidth-1:0]        dst_y_i;
  logic [XWidth-1:0]        src_x_i;
  logic [YWidth-1:0]        src_y_i;
  logic [XWidth-1:0]        mask_x_i;
  logic [YWidth-1:0]        mask_y_i;
  logic                     mcast_i;
  logic                     last_i;
  logic                     valid_i;
  logic                     ready_i;
  logic [NumRoutes-1:0]     route_sel_o;
  logic [RouteSelWidth-1:0] route_sel_id_o;
  logic                     dec_error_o;
  logic                     mismatch_o;

  modport master (
    output dst_x_i, dst_y_i, src_x_i, src_y_i, mask_x_i, mask_y_i,
    output mcast_i, last_i, valid_i, ready_i,
    input  route_sel_o, route_sel_id_o, dec_error_o, mismatch_o
  );

  modport slave (
    input  dst_x_i, dst_y_i, src_x_i, src_y_i, mask_x_i, mask_y_i,
    input  mcast_i, last_i, valid_i, ready_i,
    output route_sel_o, route_sel_id_o, dec_error_o, mismatch_o
  );

endinterface

// File: rtl/floo_route_sel_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// floo_route_sel_unit
// Route computation for one input port of a FlooNoC mesh router. Computes
// the output-port mask and index for the head flit, either by ID-table
// range decode or by XY dimension-order routing (with optional multicast
// XY-tree forwarding), and optionally holds that route for the whole
// wormhole packet until the tail flit has been transferred.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   cur_x_i, cur_y_i    this router's coordinate
//   rule_start_i        ID-table lower bounds (inclusive), packed per rule
//   rule_end_i          ID-table upper bounds (exclusive), packed per rule
//   rule_idx_i          ID-table output-port index, packed per rule
//   flit                slave side of floo_route_sel_unit_if (flit fields,
//                       handshake, selected route, error flags)
//
// Output port map: 0 Eject, 1 South (-y), 2 West (-x), 3 North (+y),
// 4 East (+x).
// -----------------------------------------------------------------------------
module floo_route_sel_unit #(
  parameter int unsigned RouteAlgo     = 1,  // 0 IdTable, 1 XYRouting
  parameter int unsigned NumRoutes     = 5,
  parameter int unsigned XWidth        = 3,
  parameter int unsigned YWidth        = 3,
  parameter int unsigned IdWidth       = XWidth + YWidth,
  parameter int unsigned NumAddrRules  = 4,
  parameter int unsigned RouteSelWidth = $clog2(NumRoutes),
  parameter bit          EnMultiCast   = 1'b1,
  parameter bit          LockRouting   = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [XWidth-1:0]                   cur_x_i,
  input  logic [YWidth-1:0]                   cur_y_i,
  input  logic [NumAddrRules*IdWidth-1:0]     rule_start_i,
  input  logic [NumAddrRules*IdWidth-1:0]     rule_end_i,
  input  logic [NumAddrRules*RouteSelWidth-1:0] rule_idx_i,
  floo_route_sel_unit_if.slave                flit
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (RouteAlgo > 1) begin : g_bad_algo
    $fatal(1, "floo_route_sel_unit: RouteAlgo must be 0 (IdTable) or 1 (XYRouting)");
  end
  if (RouteAlgo == 1 && NumRoutes != 5) begin : g_bad_routes
    $fatal(1, "floo_route_sel_unit: XYRouting requires NumRoutes == 5");
  end

  // ---------------------------------------------------------------------------
  // Fresh (combinational) route for the flit currently presented
  // ---------------------------------------------------------------------------
  logic [NumRoutes-1:0]     fresh_sel;
  logic [RouteSelWidth-1:0] fresh_id;
  logic                     fresh_dec_err;
  logic                     handshake;

  assign handshake = flit.valid_i & flit.ready_i;

  if (RouteAlgo == 0) begin : g_idtable
    logic [IdWidth-1:0]       dst_id;
    logic [RouteSelWidth-1:0] hit_idx;
    logic                     hit;
    logic                     unused_xy_inputs;

    assign dst_id = {flit.dst_y_i, flit.dst_x_i};

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path leaves it unassigned and no latch is
    // inferred.
    always_comb begin
      hit_idx = '0;
      hit     = 1'b0;
      // Scanning upward and overwriting on each match makes the
      // highest-numbered matching rule win.
      for (int unsigned r = 0; r < NumAddrRules; r++) begin
        if ((dst_id >= rule_start_i[r*IdWidth +: IdWidth]) &&
            (dst_id <  rule_end_i[r*IdWidth +: IdWidth])) begin
          hit     = 1'b1;
          hit_idx = rule_idx_i[r*RouteSelWidth +: RouteSelWidth];
        end
      end
    end

    assign fresh_id      = hit_idx;
    assign fresh_sel     = NumRoutes'(1) << hit_idx;
    assign fresh_dec_err = ~hit;

    // Coordinate and multicast fields play no part in table decode.
    assign unused_xy_inputs = ^{cur_x_i, cur_y_i, flit.src_x_i, flit.src_y_i,
                                flit.mask_x_i, flit.mask_y_i, flit.mcast_i};

  end else begin : g_xy
    localparam int unsigned PortEject = 0;
    localparam int unsigned PortSouth = 1;
    localparam int unsigned PortWest  = 2;
    localparam int unsigned PortNorth = 3;
    localparam int unsigned PortEast  = 4;

    logic [RouteSelWidth-1:0] uni_id;
    logic [NumRoutes-1:0]     uni_sel;
    logic [NumRoutes-1:0]     mc_sel;
    logic [XWidth-1:0]        x_lo, x_hi;
    logic [YWidth-1:0]        y_lo, y_hi;
    logic                     cur_in_x, cur_in_y, x_phase;
    logic                     unused_rule_inputs;

    // Dimension-order unicast: resolve X first, then Y, eject on arrival.
    always_comb begin
      uni_id = RouteSelWidth'(PortEject);
      if (flit.dst_x_i == cur_x_i && flit.dst_y_i == cur_y_i) begin
        uni_id = RouteSelWidth'(PortEject);
      end else if (flit.dst_x_i == cur_x_i) begin
        uni_id = (flit.dst_y_i < cur_y_i) ? RouteSelWidth'(PortSouth)
                                          : RouteSelWidth'(PortNorth);
      end else begin
        uni_id = (flit.dst_x_i < cur_x_i) ? RouteSelWidth'(PortWest)
                                          : RouteSelWidth'(PortEast);
      end
    end

    assign uni_sel = NumRoutes'(1) << uni_id;

    // A masked destination set is a sub-cube: its smallest member clears all
    // don't-care bits and its largest sets them. "Some member above/below
    // the current coordinate" therefore reduces to one compare against the
    // extreme member.
    assign x_lo     = flit.dst_x_i & ~flit.mask_x_i;
    assign x_hi     = flit.dst_x_i |  flit.mask_x_i;
    assign y_lo     = flit.dst_y_i & ~flit.mask_y_i;
    assign y_hi     = flit.dst_y_i |  flit.mask_y_i;
    assign cur_in_x = (cur_x_i & ~flit.mask_x_i) == x_lo;
    assign cur_in_y = (cur_y_i & ~flit.mask_y_i) == y_lo;

    // The tree still fans out along X unless the flit arrived in this column
    // from another row (then it is already in its Y branch). At the source
    // router both phases are open.
    assign x_phase = (flit.src_x_i != cur_x_i) | (flit.src_y_i == cur_y_i);

    always_comb begin
      mc_sel            = '0;
      mc_sel[PortEject] = cur_in_x & cur_in_y;
      mc_sel[PortEast]  = x_phase & (flit.src_x_i <= cur_x_i) & (x_hi > cur_x_i);
      mc_sel[PortWest]  = x_phase & (flit.src_x_i >= cur_x_i) & (x_lo < cur_x_i);
      mc_sel[PortNorth] = cur_in_x & (flit.src_y_i <= cur_y_i) & (y_hi > cur_y_i);
      mc_sel[PortSouth] = cur_in_x & (flit.src_y_i >= cur_y_i) & (y_lo < cur_y_i);
    end

    // The port index always reports the unicast direction, even for
    // multicast flits.
    assign fresh_id      = uni_id;
    assign fresh_sel     = (EnMultiCast && flit.mcast_i) ? mc_sel : uni_sel;
    assign fresh_dec_err = 1'b0;

    assign unused_rule_inputs = ^{rule_start_i, rule_end_i, rule_idx_i};
  end

  // ---------------------------------------------------------------------------
  // Wormhole lock
  // ---------------------------------------------------------------------------
  if (LockRouting) begin : g_lock
    typedef enum logic {
      StUnlocked = 1'b0,
      StLocked   = 1'b1
    } lock_state_e;

    lock_state_e              lock_q, lock_d;
    logic [NumRoutes-1:0]     sel_q, sel_d;
    logic [RouteSelWidth-1:0] id_q, id_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    // The held route is reset too, so a packet cut by reset never leaks a
    // stale selection into the next packet.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        lock_q <= StUnlocked;
        sel_q  <= '0;
        id_q   <= '0;
      end else begin
        lock_q <= lock_d;
        sel_q  <= sel_d;
        id_q   <= id_d;
      end
    end

    // While unlocked the registers shadow the fresh route every cycle, so on
    // the head handshake they already hold the head's route when the lock
    // closes. A head that is also the tail never locks.
    always_comb begin
      lock_d = lock_q;
      sel_d  = sel_q;
      id_d   = id_q;
      if (lock_q == StUnlocked) begin
        sel_d = fresh_sel;
        id_d  = fresh_id;
      end
      if (handshake) begin
        lock_d = flit.last_i ? StUnlocked : StLocked;
      end
    end

    assign flit.route_sel_o    = (lock_q == StLocked) ? sel_q : fresh_sel;
    assign flit.route_sel_id_o = (lock_q == StLocked) ? id_q  : fresh_id;
    assign flit.mismatch_o     = handshake && (lock_q == StLocked) &&
                                 ({fresh_sel, fresh_id} != {sel_q, id_q});

  end else begin : g_no_lock
    logic unused_lock_inputs;

    assign flit.route_sel_o    = fresh_sel;
    assign flit.route_sel_id_o = fresh_id;
    assign flit.mismatch_o     = 1'b0;

    assign unused_lock_inputs = ^{clk_i, rst_i, handshake, flit.last_i};
  end

  assign flit.dec_error_o = fresh_dec_err;

endmodule

// File: tb/tb_floo_route_sel_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_floo_route_sel_unit
// Two instances: one in XY routing mode (multicast and lock enabled) and one
// in ID-table mode. A behavioural model computes the expected route from the
// routing rules by enumerating coordinates and rules, and tracks wormhole
// packets as a simple "inside packet / held route" pair. A compare process
// checks both instances every cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_floo_route_sel_unit;

  localparam int XW = 3;
  localparam int YW = 3;
  localparam int IW = XW + YW;
  localparam int NR = 5;
  localparam int SW = 3;
  localparam int NRULES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [XW-1:0] xy_cur_x, idt_cur_x;
  logic [YW-1:0] xy_cur_y, idt_cur_y;
  logic [NRULES*IW-1:0] rs, re;
  logic [NRULES*SW-1:0] ri;

  floo_route_sel_unit_if #(.XWidth(XW), .YWidth(YW), .NumRoutes(NR), .RouteSelWidth(SW)) xy_if ();
  floo_route_sel_unit_if #(.XWidth(XW), .YWidth(YW), .NumRoutes(NR), .RouteSelWidth(SW)) idt_if ();

  floo_route_sel_unit #(
    .RouteAlgo(1), .NumRoutes(NR), .XWidth(XW), .YWidth(YW), .NumAddrRules(NRULES),
    .RouteSelWidth(SW), .EnMultiCast(1'b1), .LockRouting(1'b1)
  ) u_xy (
    .clk_i(clk), .rst_i(rst), .cur_x_i(xy_cur_x), .cur_y_i(xy_cur_y),
    .rule_start_i(rs), .rule_end_i(re), .rule_idx_i(ri), .flit(xy_if)
  );

  floo_route_sel_unit #(
    .RouteAlgo(0), .NumRoutes(NR), .XWidth(XW), .YWidth(YW), .NumAddrRules(NRULES),
    .RouteSelWidth(SW), .EnMultiCast(1'b1), .LockRouting(1'b1)
  ) u_idt (
    .clk_i(clk), .rst_i(rst), .cur_x_i(idt_cur_x), .cur_y_i(idt_cur_y),
    .rule_start_i(rs), .rule_end_i(re), .rule_idx_i(ri), .flit(idt_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic int uni_model(input int cx, input int cy, input int dx, input int dy);
    if (dx == cx && dy == cy) return 0;
    if (dx == cx) return (dy < cy) ? 1 : 3;
    return (dx < cx) ? 2 : 4;
  endfunction

  // Enumerate every coordinate of the masked destination sets.
  function automatic logic [4:0] mc_model(input int cx, input int cy, input int sx, input int sy,
                                          input int dx, input int dy, input int mx, input int my);
    bit in_x = 0, in_y = 0, any_e = 0, any_w = 0, any_n = 0, any_s = 0, xph;
    logic [4:0] s = '0;
    for (int x = 0; x < (1 << XW); x++) begin
      if ((x & ~mx) == (dx & ~mx)) begin
        if (x == cx) in_x = 1;
        if (x > cx)  any_e = 1;
        if (x < cx)  any_w = 1;
      end
    end
    for (int y = 0; y < (1 << YW); y++) begin
      if ((y & ~my) == (dy & ~my)) begin
        if (y == cy) in_y = 1;
        if (y > cy)  any_n = 1;
        if (y < cy)  any_s = 1;
      end
    end
    xph  = (sx != cx) || (sx == cx && sy == cy);
    s[0] = in_x && in_y;
    s[4] = xph && (sx <= cx) && any_e;
    s[2] = xph && (sx >= cx) && any_w;
    s[3] = in_x && (sy <= cy) && any_n;
    s[1] = in_x && (sy >= cy) && any_s;
    return s;
  endfunction

  // {sel[4:0], id[2:0]} of the fresh XY route for the current inputs.
  function automatic logic [7:0] xy_fresh();
    int id;
    logic [4:0] sel;
    id = uni_model(int'(xy_cur_x), int'(xy_cur_y), int'(xy_if.dst_x_i), int'(xy_if.dst_y_i));
    if (xy_if.mcast_i)
      sel = mc_model(int'(xy_cur_x), int'(xy_cur_y), int'(xy_if.src_x_i), int'(xy_if.src_y_i),
                     int'(xy_if.dst_x_i), int'(xy_if.dst_y_i), int'(xy_if.mask_x_i), int'(xy_if.mask_y_i));
    else
      sel = 5'(1 << id);
    return {sel, 3'(id)};
  endfunction

  // {sel[4:0], id[2:0], err} of the table decode.
  function automatic logic [8:0] idt_fresh();
    int id;
    int idx = 0;
    bit hit = 0;
    id = int'({idt_if.dst_y_i, idt_if.dst_x_i});
    for (int r = 0; r < NRULES; r++) begin
      if (id >= int'(rs[r*IW +: IW]) && id < int'(re[r*IW +: IW])) begin
        hit = 1;
        idx = int'(ri[r*SW +: SW]);
      end
    end
    return {5'(1 << idx), 3'(idx), !hit};
  endfunction

  // Packet tracker for the XY port: inside a packet the route seen at the
  // head is held until the tail is handed over.
  bit         in_pkt;
  logic [7:0] held;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt <= 1'b0;
      held   <= '0;
    end else if (xy_if.valid_i && xy_if.ready_i) begin
      if (!in_pkt && !xy_if.last_i) begin
        in_pkt <= 1'b1;
        held   <= xy_fresh();
      end else if (in_pkt && xy_if.last_i) begin
        in_pkt <= 1'b0;
      end
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      logic [7:0] f, e;
      logic [8:0] t;
      bit hs;
      f  = xy_fresh();
      e  = in_pkt ? held : f;
      hs = xy_if.valid_i && xy_if.ready_i;
      check("xy_sel",      xy_if.route_sel_o,    e[7:3]);
      check("xy_id",       xy_if.route_sel_id_o, e[2:0]);
      check("xy_mismatch", xy_if.mismatch_o,     hs && in_pkt && (f != held));
      check("xy_dec_err",  xy_if.dec_error_o,    1'b0);
      t = idt_fresh();
      check("idt_sel",     idt_if.route_sel_o,    t[8:4]);
      check("idt_id",      idt_if.route_sel_id_o, t[3:1]);
      check("idt_dec_err", idt_if.dec_error_o,    t[0]);
      check("idt_mismatch", idt_if.mismatch_o,    1'b0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_xy(input int dx, input int dy, input bit v, input bit r, input bit l);
    xy_if.dst_x_i  = XW'(dx);
    xy_if.dst_y_i  = YW'(dy);
    xy_if.src_x_i  = '0;
    xy_if.src_y_i  = '0;
    xy_if.mask_x_i = '0;
    xy_if.mask_y_i = '0;
    xy_if.mcast_i  = 1'b0;
    xy_if.valid_i  = v;
    xy_if.ready_i  = r;
    xy_if.last_i   = l;
  endtask

  task automatic set_rule(input int r, input int s, input int e, input int idx);
    rs[r*IW +: IW] = IW'(s);
    re[r*IW +: IW] = IW'(e);
    ri[r*SW +: SW] = SW'(idx);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_xy(input string name, input logic [4:0] sel, input int id, input bit mm);
    @(negedge clk);
    check({name, "_sel"}, xy_if.route_sel_o, sel);
    check({name, "_id"},  xy_if.route_sel_id_o, id);
    check({name, "_mm"},  xy_if.mismatch_o, mm);
  endtask

  task automatic check_idt(input string name, input int y, input int x,
                           input logic [4:0] sel, input int id, input bit err);
    idt_if.dst_y_i = YW'(y);
    idt_if.dst_x_i = XW'(x);
    @(negedge clk);
    check({name, "_sel"}, idt_if.route_sel_o, sel);
    check({name, "_id"},  idt_if.route_sel_id_o, id);
    check({name, "_err"}, idt_if.dec_error_o, err);
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    xy_cur_x = 3'd1; xy_cur_y = 3'd1;
    idt_cur_x = '0;  idt_cur_y = '0;
    rs = '0; re = '0; ri = '0;
    set_rule(0, 0, 8, 4);
    set_rule(1, 8, 16, 2);
    set_rule(2, 8, 10, 1);
    set_rule(3, 0, 0, 0);
    drive_xy(1, 1, 0, 0, 0);
    idt_if.dst_x_i = '0; idt_if.dst_y_i = '0; idt_if.src_x_i = '0; idt_if.src_y_i = '0;
    idt_if.mask_x_i = '0; idt_if.mask_y_i = '0; idt_if.mcast_i = 1'b0;
    idt_if.last_i = 1'b0; idt_if.valid_i = 1'b0; idt_if.ready_i = 1'b0;

    // Reset state: unlocked, outputs follow the fresh route.
    repeat (2) @(negedge clk);
    check("rst_sel", xy_if.route_sel_o, 5'b00001);
    check("rst_mm",  xy_if.mismatch_o, 1'b0);
    next_cycle();
    rst    = 1'b0;
    cmp_en = 1'b1;

    // XY unicast from (1,1).
    drive_xy(1, 1, 0, 0, 0); check_xy("uc_eject", 5'b00001, 0, 0); next_cycle();
    drive_xy(1, 3, 0, 0, 0); check_xy("uc_north", 5'b01000, 3, 0); next_cycle();
    drive_xy(0, 2, 0, 0, 0); check_xy("uc_west",  5'b00100, 2, 0); next_cycle();
    drive_xy(5, 0, 0, 0, 0); check_xy("uc_east",  5'b10000, 4, 0); next_cycle();
    drive_xy(1, 0, 0, 0, 0); check_xy("uc_south", 5'b00010, 1, 0); next_cycle();

    // XY multicast at the source, then in transit one hop east.
    drive_xy(0, 0, 0, 0, 0);
    xy_if.mcast_i = 1'b1; xy_if.src_x_i = 3'd1; xy_if.src_y_i = 3'd1;
    xy_if.mask_x_i = 3'b011; xy_if.mask_y_i = 3'b000;
    check_xy("mc_src", 5'b10110, 2, 0); next_cycle();
    xy_cur_x = 3'd2;
    check_xy("mc_transit", 5'b10010, 2, 0); next_cycle();
    xy_cur_x = 3'd1;

    // Lock sequence.
    drive_xy(3, 1, 1, 1, 0); check_xy("lk_head", 5'b10000, 4, 0); next_cycle();
    drive_xy(0, 1, 1, 1, 0); check_xy("lk_body", 5'b10000, 4, 1); next_cycle();
    drive_xy(0, 1, 1, 1, 1); check_xy("lk_tail", 5'b10000, 4, 1); next_cycle();
    drive_xy(0, 1, 0, 0, 0); check_xy("lk_free", 5'b00100, 2, 0); next_cycle();

    // Single-flit packet never locks.
    drive_xy(3, 1, 1, 1, 1); check_xy("sf_head", 5'b10000, 4, 0); next_cycle();
    drive_xy(0, 1, 0, 0, 0); check_xy("sf_after", 5'b00100, 2, 0); next_cycle();

    // Reset while locked.
    drive_xy(3, 1, 1, 1, 0); check_xy("rl_head", 5'b10000, 4, 0); next_cycle();
    drive_xy(0, 1, 0, 0, 0); check_xy("rl_held", 5'b10000, 4, 0);
    next_cycle();
    rst = 1'b1; #2; rst = 1'b0;
    check_xy("rl_fresh", 5'b00100, 2, 0); next_cycle();
    drive_xy(0, 1, 1, 1, 1); check_xy("rl_next", 5'b00100, 2, 0); next_cycle();
    drive_xy(1, 1, 0, 0, 0);

    // ID table, including range boundaries and overlap priority.
    check_idt("id9",  1, 1, 5'b00010, 1, 0);
    check_idt("id12", 1, 4, 5'b00100, 2, 0);
    check_idt("id20", 2, 4, 5'b00001, 0, 1);
    check_idt("id8",  1, 0, 5'b00010, 1, 0);
    check_idt("id10", 1, 2, 5'b00100, 2, 0);
    check_idt("id7",  0, 7, 5'b10000, 4, 0);
    check_idt("id16", 2, 0, 5'b00001, 0, 1);

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst = ($urandom_range(0, 199) == 0);
      if (i % 64 == 0) begin
        xy_cur_x = XW'($urandom);
        xy_cur_y = YW'($urandom);
      end
      if (i % 100 == 0) begin
        for (int r = 0; r < NRULES; r++) begin
          int s;
          s = int'($urandom_range(0, 63));
          set_rule(r, s, s + int'($urandom_range(0, 20)), int'($urandom_range(0, 7)));
        end
      end
      xy_if.dst_x_i  = XW'($urandom);
      xy_if.dst_y_i  = YW'($urandom);
      xy_if.src_x_i  = ($urandom_range(0, 1) != 0) ? xy_cur_x : XW'($urandom);
      xy_if.src_y_i  = ($urandom_range(0, 1) != 0) ? xy_cur_y : YW'($urandom);
      xy_if.mask_x_i = ($urandom_range(0, 2) == 0) ? '0 : XW'($urandom);
      xy_if.mask_y_i = ($urandom_range(0, 2) == 0) ? '0 : YW'($urandom);
      xy_if.mcast_i  = ($urandom_range(0, 2) == 0);
      xy_if.last_i   = ($urandom_range(0, 3) == 0);
      xy_if.valid_i  = ($urandom_range(0, 1) != 0);
      xy_if.ready_i  = ($urandom_range(0, 3) != 0);
      idt_if.dst_x_i = XW'($urandom);
      idt_if.dst_y_i = YW'($urandom);
      idt_if.mcast_i = ($urandom_range(0, 1) != 0);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/floo_route_sel_unit.md
Name: floo_route_sel_unit

Overview:
- Per-input-port route computation for a FlooNoC mesh router.
- Produces a one-hot output-port mask and a binary port index for the head flit of each input port.
- Two modes:
  - ID-table lookup: range-rule decode of the destination ID.
  - XY dimension-order routing, with optional multicast: mask-based destination sets, XY-tree forwarding.
- Optional wormhole lock holds the selection until the tail flit is transferred.

Parameters:
- RouteAlgo, 1, 0 = IdTable, 1 = XYRouting; any other value is a fatal elaboration error.
- NumRoutes, 5, number of output ports. Must be 5 for XYRouting.
- XWidth, 3, width of the X coordinate.
- YWidth, 3, width of the Y coordinate.
- IdWidth, XWidth+YWidth, flat ID, formed as {y,x}.
- NumAddrRules, 4, number of ID-table rules.
- RouteSelWidth, $clog2(NumRoutes), width of the port index.
- EnMultiCast, 1, enables the multicast mask path (XYRouting only).
- LockRouting, 1, enables the wormhole lock.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cur_x_i  in  XWidth  this router's X coordinate
- cur_y_i  in  YWidth  this router's Y coordinate
- rule_start_i  in  NumAddrRules*IdWidth  rule lower bounds, inclusive
- rule_end_i  in  NumAddrRules*IdWidth  rule upper bounds, exclusive
- rule_idx_i  in  NumAddrRules*RouteSelWidth  port index per rule
- dst_x_i  in  XWidth  destination X coordinate
- dst_y_i  in  YWidth  destination Y coordinate
- src_x_i  in  XWidth  source X coordinate (multicast)
- src_y_i  in  YWidth  source Y coordinate (multicast)
- mask_x_i  in  XWidth  multicast don't-care bits for X
- mask_y_i  in  YWidth  multicast don't-care bits for Y
- mcast_i  in  1  flit is a multicast
- last_i  in  1  tail flit
- valid_i  in  1  flit valid
- ready_i  in  1  flit accepted downstream
- route_sel_o  out  NumRoutes  one-hot (unicast) or multi-hot (multicast) output mask
- route_sel_id_o  out  RouteSelWidth  binary port index
- dec_error_o  out  1  IdTable: no rule matched
- mismatch_o  out  1  locked route differs from the freshly computed route

Behaviour:
- Port map: 0 Eject, 1 South (y decreasing), 2 West (x decreasing), 3 North (y increasing), 4 East (x increasing).
- Route computation is combinational.

IdTable mode:
- Rule i matches when start_i <= {dst_y,dst_x} < end_i.
- If several rules match, the highest-numbered rule wins.
- No match: index 0 and dec_error_o=1.
- route_sel = 1 << idx.
- dec_error_o is always 0 in XY mode.

XY unicast:
- dst == cur → Eject.
- Else x equal → South if dst_y < cur_y, otherwise North.
- Else → West if dst_x < cur_x, otherwise East.
- Comparisons are unsigned.
- route_sel is one-hot of the resulting index.

XY multicast (EnMultiCast=1 and mcast_i=1):
- X set = all x with (x & ~mask_x) == (dst_x & ~mask_x). Y set is defined likewise.
- The bit set is the OR of the following conditions:
  - Eject: cur_x ∈ Xset and cur_y ∈ Yset.
  - x-phase: src_x != cur_x, or (src_x == cur_x and src_y == cur_y).
  - East: x-phase, src_x <= cur_x, and some x ∈ Xset with x > cur_x.
  - West: x-phase, src_x >= cur_x, and some x ∈ Xset with x < cur_x.
  - North: cur_x ∈ Xset, src_y <= cur_y, and some y ∈ Yset with y > cur_y.
  - South: cur_x ∈ Xset, src_y >= cur_y, and some y ∈ Yset with y < cur_y.
- route_sel_id_o still carries the unicast index.
- With EnMultiCast=0, mcast_i is ignored and unicast routing is always used.

Lock (LockRouting=1):
- locked_q resets to 0.
- On valid_i & ready_i: locked_d = ~last_i.
- While ~locked_q, sel_q and id_q register the fresh route every cycle.
- Outputs = locked_q ? registered values : fresh values.
- A single-flit packet (last_i=1 at head) never locks.
- mismatch_o = valid_i & ready_i & locked_q & (fresh route != registered route), combinational.
- Reset mid-packet clears the lock and sel_q/id_q to 0; the next flit is routed fresh.

LockRouting=0:
- Outputs are always the fresh route.
- mismatch_o=0.

Test Plan:
- Test setup: XY mode, cur=(1,1).
- XY unicast:
  - dst (1,1) → route_sel_o=00001, id=0.
  - dst (1,3) → 01000, id=3.
  - dst (0,2) → 00100, id=2.
  - dst (5,0) → 10000, id=4.
- XY multicast: cur=(1,1), src=(1,1), dst=(0,0), mask_x=011, mask_y=000 → route_sel_o=10110 (East, West, South; no Eject).
- Multicast transit: cur=(2,1), src=(1,1), same set → route_sel_o=10010 (East, South; no West).
- Lock sequence:
  - Head dst (3,1), last=0, handshake → East.
  - Next flit dst (0,1) → route_sel_o still 10000, mismatch_o=1.
  - Tail (last=1) handshake → next cycle unlocked; dst (0,1) → 00100.
- IdTable: rules {0,8,idx4} and {8,16,idx2}, plus overlapping {8,10,idx1}.
  - id 9 → idx 1, route_sel_o=00010.
  - id 12 → idx 2, route_sel_o=00100.
  - id 20 → idx 0, route_sel_o=00001, dec_error_o=1.
- Reset: rst_i pulsed while locked → locked cleared, outputs follow the fresh route next cycle.
